// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard/redirect controller:
//   - hz_state_e : controller FSM states (RUN, REDIRECT)
//   - XLEN_DEF   : default address/PC width
//   - REGW_DEF   : default register index width
//   - PC_RESET   : reset value of the redirect target register
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    localparam logic [31:0] PC_RESET = 32'h0;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Fetch-stage control bundle between the hazard controller and the
// IF stage / pipeline registers.
//   PCOP              : 1 = PC loads NPC, 0 = PC+4
//   NPC               : registered redirect target
//   write_enable      : PC write enable
//   ifid_write_enable : IF/ID register enable
//   ifid_flush        : IF/ID loads a bubble
//   idex_flush        : ID/EX loads a bubble
//   pipe_hold         : freeze for ID/EX, EX/MEM and MEM/WB
// Modports: master = controller (drives), slave = fetch stage (consumes).
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int XLEN = 32
);
    logic            PCOP;
    logic [XLEN-1:0] NPC;
    logic            write_enable;
    logic            ifid_write_enable;
    logic            ifid_flush;
    logic            idex_flush;
    logic            pipe_hold;

    modport master (
        output PCOP, NPC, write_enable, ifid_write_enable,
               ifid_flush, idex_flush, pipe_hold
    );

    modport slave (
        input  PCOP, NPC, write_enable, ifid_write_enable,
               ifid_flush, idex_flush, pipe_hold
    );
endinterface

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// ---------------------------------------------------------------------------
// lu_detect
// Purely combinational load-use comparator. Flags when the instruction in
// ID reads a register that the load currently in EXE will write. Register 0
// is hard-wired, so a load targeting x0 never creates a hazard. Kept free of
// state so the forwarding unit can reuse it.
// Ports:
//   ex_memread          : EXE instruction is a load
//   ex_rd               : EXE destination register
//   id_rs1, id_rs2      : ID source registers
//   id_use_rs1/rs2      : ID instruction actually reads rs1/rs2
//   lu_hazard           : load-use hazard detected
// ---------------------------------------------------------------------------
module lu_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REGW = REGW_DEF
) (
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rd,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    output logic            lu_hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu_hazard = ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and redirect controller for the 5-stage pipeline. Resolves
// data-memory stalls, taken branches/jumps from EXE, and load-use hazards,
// in that priority order. The redirect target is registered to break the
// EXE-to-PC path; the extra wrong-path fetch this causes is squashed while
// the FSM sits in REDIRECT.
// Ports:
//   clk, rst (async, active-low)
//   ex_branch_taken, ex_target  : EXE redirect request and target
//   ex_memread, ex_rd           : EXE load information
//   id_rs1/rs2, id_use_rs1/rs2  : ID source operands
//   mem_busy                    : data memory not ready, freeze everything
//   fe (pipe_hazard_ctrl_if.master) : fetch/pipeline-register controls
// Optional build macro HAZARD_STATS_EN adds three 32-bit wrapping counters:
//   stat_lu_stalls, stat_redirects, stat_mem_stalls.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_branch_taken,
    input  logic [XLEN-1:0]    ex_target,
    input  logic               ex_memread,
    input  logic [REGW-1:0]    ex_rd,
    input  logic [REGW-1:0]    id_rs1,
    input  logic [REGW-1:0]    id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic               mem_busy,
`ifdef HAZARD_STATS_EN
    output logic [31:0]        stat_lu_stalls,
    output logic [31:0]        stat_redirects,
    output logic [31:0]        stat_mem_stalls,
`endif
    pipe_hazard_ctrl_if.master fe
);

    hz_state_e       state_q, state_d;
    logic            pcop_q, pcop_d;
    logic [XLEN-1:0] npc_q, npc_d;

    logic lu_hazard;
    logic write_enable;
    logic ifid_write_enable;
    logic ifid_flush;
    logic idex_flush;
    logic lu_stall;
    logic redirect_start;

    lu_detect #(
        .REGW (REGW)
    ) u_lu_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .lu_hazard  (lu_hazard)
    );

    // Per-cycle control decision. mem_busy freezes everything; REDIRECT
    // masks new branches and load-use so the wrong-path fetch is only
    // squashed; in RUN a branch outranks a (never co-valid) load-use.
    always_comb begin
        state_d           = state_q;
        pcop_d            = pcop_q;
        npc_d             = npc_q;
        write_enable      = 1'b1;
        ifid_write_enable = 1'b1;
        ifid_flush        = 1'b0;
        idex_flush        = 1'b0;
        lu_stall          = 1'b0;
        redirect_start    = 1'b0;

        if (mem_busy) begin
            write_enable      = 1'b0;
            ifid_write_enable = 1'b0;
        end else if (state_q == REDIRECT) begin
            ifid_flush = 1'b1;
            pcop_d     = 1'b0;
            state_d    = RUN;
        end else if (ex_branch_taken) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            npc_d          = ex_target;
            pcop_d         = 1'b1;
            state_d        = REDIRECT;
            redirect_start = 1'b1;
        end else if (lu_hazard) begin
            write_enable      = 1'b0;
            ifid_write_enable = 1'b0;
            idex_flush        = 1'b1;
            lu_stall          = 1'b1;
        end
    end

    // FSM state and registered redirect outputs. Reset drops PCOP at once,
    // discarding any redirect that was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pcop_q  <= 1'b0;
            npc_q   <= XLEN'(PC_RESET);
        end else begin
            state_q <= state_d;
            pcop_q  <= pcop_d;
            npc_q   <= npc_d;
        end
    end

    assign fe.PCOP              = pcop_q;
    assign fe.NPC               = npc_q;
    assign fe.write_enable      = write_enable;
    assign fe.ifid_write_enable = ifid_write_enable;
    assign fe.ifid_flush        = ifid_flush;
    assign fe.idex_flush        = idex_flush;
    assign fe.pipe_hold         = mem_busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;
    logic [31:0] mem_cnt_q, mem_cnt_d;

    // Event counters; plain 32-bit adds so they wrap naturally.
    always_comb begin
        lu_cnt_d    = lu_cnt_q    + {31'd0, lu_stall};
        redir_cnt_d = redir_cnt_q + {31'd0, redirect_start};
        mem_cnt_d   = mem_cnt_q   + {31'd0, mem_busy};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_cnt_q    <= '0;
            redir_cnt_q <= '0;
            mem_cnt_q   <= '0;
        end else begin
            lu_cnt_q    <= lu_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
        end
    end

    assign stat_lu_stalls  = lu_cnt_q;
    assign stat_redirects  = redir_cnt_q;
    assign stat_mem_stalls = mem_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = lu_stall ^ redirect_start;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// a randomized run compared against a behavioural model of the controller.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Honours HAZARD_STATS_EN when defined.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_branch_taken;
    logic [31:0] ex_target;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        mem_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_lu_stalls;
    logic [31:0] stat_redirects;
    logic [31:0] stat_mem_stalls;
`endif

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl_if #(.XLEN(32)) fe_if ();

    pipe_hazard_ctrl #(
        .XLEN (32),
        .REGW (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_branch_taken (ex_branch_taken),
        .ex_target       (ex_target),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .mem_busy        (mem_busy),
`ifdef HAZARD_STATS_EN
        .stat_lu_stalls  (stat_lu_stalls),
        .stat_redirects  (stat_redirects),
        .stat_mem_stalls (stat_mem_stalls),
`endif
        .fe              (fe_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of pipeline inputs.
    task automatic applyStimulus(input bit br, input logic [31:0] tgt,
                                 input bit mr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input bit u1, input bit u2, input bit busy);
        ex_branch_taken = br;
        ex_target       = tgt;
        ex_memread      = mr;
        ex_rd           = rd;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_use_rs1      = u1;
        id_use_rs2      = u2;
        mem_busy        = busy;
    endtask

    task automatic idle();
        applyStimulus(0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held with a branch request active; registers must stay cleared
    // and the FSM must come out in RUN.
    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(1, 32'h5555_5554, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fe_if.PCOP !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_pcop: got %b expected 0", fe_if.PCOP);
            end
            checks++;
            if (fe_if.NPC !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_npc: got %h expected 00000000", fe_if.NPC);
            end
            tick();
        end
        idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({fe_if.PCOP, fe_if.ifid_flush, fe_if.idex_flush, fe_if.write_enable,
             fe_if.ifid_write_enable, fe_if.pipe_hold} !== 6'b000110) begin
            errors++;
            $display("[TB] FAIL reset_release_run: got %b expected 000110",
                     {fe_if.PCOP, fe_if.ifid_flush, fe_if.idex_flush,
                      fe_if.write_enable, fe_if.ifid_write_enable, fe_if.pipe_hold});
        end
        tick();
    endtask

    // Taken branch: flush in N, PCOP/NPC in N+1 with IF/ID squash, RUN in N+2.
    task automatic test_branch();
        applyStimulus(1, 32'h0000_0100, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({fe_if.ifid_flush, fe_if.idex_flush, fe_if.write_enable} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL branch_n_flush: got %b expected 111",
                     {fe_if.ifid_flush, fe_if.idex_flush, fe_if.write_enable});
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (fe_if.PCOP !== 1'b1 || fe_if.NPC !== 32'h100 || fe_if.ifid_flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL branch_n1: got pcop=%b npc=%h ifid_flush=%b expected 1 00000100 1",
                     fe_if.PCOP, fe_if.NPC, fe_if.ifid_flush);
        end
        tick();
        @(negedge clk);
        checks++;
        if (fe_if.PCOP !== 1'b0 || fe_if.ifid_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL branch_n2: got pcop=%b ifid_flush=%b expected 0 0",
                     fe_if.PCOP, fe_if.ifid_flush);
        end
        tick();
    endtask

    // Load-use on rs2 stalls exactly one cycle; a load to x0 never stalls.
    task automatic test_load_use();
        applyStimulus(0, 32'h0, 1, 5'd5, 5'd1, 5'd5, 0, 1, 0);
        @(negedge clk);
        checks++;
        if ({fe_if.write_enable, fe_if.ifid_write_enable, fe_if.idex_flush} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL lu_stall: got %b expected 001",
                     {fe_if.write_enable, fe_if.ifid_write_enable, fe_if.idex_flush});
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({fe_if.write_enable, fe_if.ifid_write_enable, fe_if.idex_flush} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL lu_release: got %b expected 110",
                     {fe_if.write_enable, fe_if.ifid_write_enable, fe_if.idex_flush});
        end
        tick();
        applyStimulus(0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        @(negedge clk);
        checks++;
        if ({fe_if.write_enable, fe_if.ifid_write_enable, fe_if.idex_flush} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL lu_x0: got %b expected 110",
                     {fe_if.write_enable, fe_if.ifid_write_enable, fe_if.idex_flush});
        end
        tick();
        idle();
    endtask

    // mem_busy for 3 cycles right after the branch: redirect waits, then
    // one real redirect cycle, then RUN.
    task automatic test_mem_busy_redirect();
        applyStimulus(1, 32'h0000_0200, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
            @(negedge clk);
            checks++;
            if ({fe_if.PCOP, fe_if.write_enable, fe_if.pipe_hold, fe_if.ifid_flush} !== 4'b1010
                || fe_if.NPC !== 32'h200) begin
                errors++;
                $display("[TB] FAIL busy_redirect_%0d: got pcop/we/hold/flush=%b npc=%h expected 1010 00000200",
                         i, {fe_if.PCOP, fe_if.write_enable, fe_if.pipe_hold, fe_if.ifid_flush},
                         fe_if.NPC);
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if ({fe_if.PCOP, fe_if.write_enable, fe_if.pipe_hold, fe_if.ifid_flush} !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL busy_redirect_release: got %b expected 1101",
                     {fe_if.PCOP, fe_if.write_enable, fe_if.pipe_hold, fe_if.ifid_flush});
        end
        tick();
        @(negedge clk);
        checks++;
        if (fe_if.PCOP !== 1'b0 || fe_if.ifid_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_redirect_run: got pcop=%b flush=%b expected 0 0",
                     fe_if.PCOP, fe_if.ifid_flush);
        end
        tick();
    endtask

    // New branch and load-use requests are ignored while in REDIRECT.
    task automatic test_masking();
        applyStimulus(1, 32'h0000_0300, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'hDEAD_BEEC, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (fe_if.idex_flush !== 1'b0 || fe_if.PCOP !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mask_branch_cycle: got idex_flush=%b pcop=%b expected 0 1",
                     fe_if.idex_flush, fe_if.PCOP);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (fe_if.NPC !== 32'h300 || fe_if.PCOP !== 1'b0 || fe_if.ifid_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mask_branch_after: got npc=%h pcop=%b flush=%b expected 00000300 0 0",
                     fe_if.NPC, fe_if.PCOP, fe_if.ifid_flush);
        end
        tick();
        applyStimulus(1, 32'h0000_0400, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if ({fe_if.write_enable, fe_if.ifid_write_enable, fe_if.idex_flush} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL mask_lu: got %b expected 110",
                     {fe_if.write_enable, fe_if.ifid_write_enable, fe_if.idex_flush});
        end
        tick();
        idle();
        tick();
    endtask

    // Reset in the middle of REDIRECT drops PCOP immediately and leaves RUN.
    task automatic test_reset_mid_redirect();
        applyStimulus(1, 32'h0000_0500, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        tick();
        idle();
        rst = 1'b0;
        #1;
        checks++;
        if (fe_if.PCOP !== 1'b0 || fe_if.NPC !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_redirect: got pcop=%b npc=%h expected 0 00000000",
                     fe_if.PCOP, fe_if.NPC);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (fe_if.ifid_flush !== 1'b0 || fe_if.PCOP !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_redirect_run: got flush=%b pcop=%b expected 0 0",
                     fe_if.ifid_flush, fe_if.PCOP);
        end
        tick();
    endtask

`ifdef HAZARD_STATS_EN
    // 2 load-use cycles, 1 redirect, 4 memory stall cycles after a reset.
    task automatic test_stats();
        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 32'h0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0);
            tick();
        end
        idle();
        tick();
        applyStimulus(1, 32'h0000_0600, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        tick();
        idle();
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (stat_lu_stalls !== 32'd2 || stat_redirects !== 32'd1 || stat_mem_stalls !== 32'd4) begin
            errors++;
            $display("[TB] FAIL stats_directed: got lu=%0d redir=%0d mem=%0d expected 2 1 4",
                     stat_lu_stalls, stat_redirects, stat_mem_stalls);
        end
        tick();
    endtask
`endif

    // Randomized traffic against a behavioural model. The model keeps only
    // "a redirect to target T is owed to fetch" plus event tallies.
    task automatic test_random();
        bit          owed;
        logic [31:0] owed_tgt;
        logic [31:0] last_npc;
        int          n_lu, n_redir, n_mem;
        bit          hazard;
        logic [37:0] exp_v, obs_v;
        bit          br, mr, u1, u2, busy;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] tgt;

        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
        owed = 0; owed_tgt = 32'h0; last_npc = 32'h0;
        n_lu = 0; n_redir = 0; n_mem = 0;

        for (int c = 0; c < 400; c++) begin
            br   = ($urandom_range(0, 4) == 0);
            mr   = ($urandom_range(0, 2) == 0);
            busy = ($urandom_range(0, 4) == 0);
            rd   = 5'($urandom_range(0, 7));
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            u1   = 1'($urandom_range(0, 1));
            u2   = 1'($urandom_range(0, 1));
            tgt  = {$urandom} & 32'hFFFF_FFFC;
            applyStimulus(br, tgt, mr, rd, rs1, rs2, u1, u2, busy);

            hazard = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));

            // {PCOP, NPC, we, ifid_we, ifid_flush, idex_flush, hold}
            if (busy)
                exp_v = {owed, last_npc, 5'b00001};
            else if (owed)
                exp_v = {1'b1, last_npc, 5'b11100};
            else if (br)
                exp_v = {1'b0, last_npc, 5'b11110};
            else if (hazard)
                exp_v = {1'b0, last_npc, 5'b00010};
            else
                exp_v = {1'b0, last_npc, 5'b11000};

            @(negedge clk);
            obs_v = {fe_if.PCOP, fe_if.NPC, fe_if.write_enable, fe_if.ifid_write_enable,
                     fe_if.ifid_flush, fe_if.idex_flush, fe_if.pipe_hold};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL random_cycle_%0d: got %h expected %h", c, obs_v, exp_v);
            end

            if (busy) begin
                n_mem++;
            end else if (owed) begin
                owed = 0;
            end else if (br) begin
                owed = 1; owed_tgt = tgt; last_npc = tgt; n_redir++;
            end else if (hazard) begin
                n_lu++;
            end
            tick();
        end
        idle();
`ifdef HAZARD_STATS_EN
        checks++;
        if (stat_lu_stalls !== 32'(n_lu) || stat_redirects !== 32'(n_redir)
            || stat_mem_stalls !== 32'(n_mem)) begin
            errors++;
            $display("[TB] FAIL stats_random: got lu=%0d redir=%0d mem=%0d expected %0d %0d %0d",
                     stat_lu_stalls, stat_redirects, stat_mem_stalls, n_lu, n_redir, n_mem);
        end
`endif
        if (owed_tgt === 32'hFFFF_FFFF) $display("[TB] note: unusual target");
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_branch();
        test_load_use();
        test_mem_busy_redirect();
        test_masking();
        test_reset_mid_redirect();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and redirect controller for the 5-stage pipeline. It is the producer side of the fetch-stage control interface: it drives `PCOP`, `NPC` and `write_enable` into the IF stage, and flush/hold controls into the IF/ID and ID/EX registers. It resolves three events in the pipeline: load-use hazards, taken branches and jumps resolved in EXE, and multi-cycle data-memory stalls. The redirect path is registered, which breaks the EXE-to-PC critical path; the wrong-path instructions this creates are squashed by a two-state FSM.

## Interface
Parameters:
- XLEN, 32, address/PC width
- REGW, 5, register index width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ex_branch_taken  in  1  EXE stage resolved a taken branch or jump this cycle
- ex_target  in  XLEN  redirect target from EXE
- ex_memread  in  1  EXE stage instruction is a load
- ex_rd  in  REGW  EXE stage destination register
- id_rs1, id_rs2  in  REGW  ID stage source registers
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- mem_busy  in  1  data memory not ready; whole pipeline must freeze
- PCOP  out  1  1 = PC loads `NPC`; 0 = PC+4
- NPC  out  XLEN  registered redirect target
- write_enable  out  1  PC write enable
- ifid_write_enable  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_flush  out  1  ID/EX loads a bubble
- pipe_hold  out  1  freeze for ID/EX, EX/MEM and MEM/WB (= mem_busy)

## Operation
FSM states are RUN and REDIRECT.

Per-cycle priority is mem_busy > redirect > load-use.

- **mem_busy=1 (any state):** write_enable=0, ifid_write_enable=0, pipe_hold=1, no flushes, no state change.
- **RUN, ex_branch_taken=1:**
  - ifid_flush=1, idex_flush=1, write_enable=1.
  - On the edge: `NPC`<=ex_target, PCOP<=1, state<=REDIRECT.
- **REDIRECT:**
  - PCOP=1, ifid_flush=1 to squash the PC+12 fetch.
  - ex_branch_taken and load-use detection are masked.
  - On the first edge with mem_busy=0: PCOP<=0, state<=RUN.
- **RUN, load-use:** the condition is ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Response: write_enable=0, ifid_write_enable=0, idex_flush=1 (one bubble).
  - The stall clears naturally once the load leaves EXE.
- ex_branch_taken and ex_memread are never both valid. If both are asserted, the branch wins.
- write_enable, ifid_write_enable and the flush outputs are combinational from the state and inputs. PCOP and `NPC` are registers.

## Timing
- **Reset values:** state=RUN, PCOP=0, NPC=0.
- **Values during reset** (inputs idle): write_enable=1, ifid_write_enable=1, all flushes 0, pipe_hold=0.
- **Redirect latency:**
  - Branch resolved in cycle N; PCOP=1 in cycle N+1.
  - PC==target after the N+1 edge; target instruction in ID in cycle N+3.
  - Penalty is 3 cycles.
- **mem_busy in cycle N+1:** PCOP/NPC hold until the PC is actually written.
- **Load-use:** exactly 1 stall cycle per hazard, unless mem_busy extends it.
- **Reset asserted mid-REDIRECT:** PCOP drops immediately and the pending redirect is discarded.

## Configuration
- `HAZARD_STATS_EN` defined adds three outputs, each 32-bit, wrapping at 2^32:
  - `stat_lu_stalls`: incremented each load-use stall cycle.
  - `stat_redirects`: incremented on each RUN→REDIRECT transition.
  - `stat_mem_stalls`: incremented each mem_busy cycle.
  - All three reset to 0.
- `HAZARD_STATS_EN` undefined: none of these ports or registers exist; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - state enum (RUN, REDIRECT)
  - XLEN/REGW defaults
  - reset PC constant `PC_RESET = 32'h0`, used for the `NPC` reset value
- One sub-module, `lu_detect`: purely combinational load-use comparator, reusable by the forwarding unit.
- FSM and redirect registers live in the top module.

## Test plan
- **Reset check:** hold rst low with ex_branch_taken=1, then release. Expect PCOP=0 and NPC=0 throughout reset, and the FSM still in RUN.
- **Taken branch:** ex_branch_taken=1 with ex_target=32'h0000_0100 in cycle N. Expect:
  - cycle N: ifid_flush=1, idex_flush=1
  - cycle N+1: PCOP=1, NPC=32'h100, ifid_flush=1
  - cycle N+2: PCOP=0
- **Load-use:** ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle. Expect write_enable=0, ifid_write_enable=0, idex_flush=1 for exactly that cycle. Repeat with ex_rd=0 and expect no stall.
- **mem_busy during REDIRECT:** mem_busy=1 for 3 cycles starting at N+1. Expect PCOP=1, write_enable=0 and pipe_hold=1 for those 3 cycles, then one more redirect cycle with write_enable=1, then RUN.
- **Masking:** in REDIRECT, assert ex_branch_taken with ex_target=32'hDEAD_BEEC. Expect NPC unchanged and the FSM returning to RUN.
- **Stats (`HAZARD_STATS_EN`):** drive 2 load-use cycles, 1 redirect and 4 mem_busy cycles. Expect counters equal to 2, 1 and 4.
